// File: rtl/isa_dma8_playback.sv
// isa_dma8_playback: 8-bit ISA single-cycle DMA playback channel (DRQ/DACK + IOW)
// with a sample FIFO, 8237-style transfer counter, terminal count and auto-init.
module isa_dma8_playback #(
    parameter int FIFO_DEPTH   = 16,
    parameter int SETUP_CYCLES = 2,
    parameter int IOW_CYCLES   = 4,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          count_load,
    input  logic [15:0]                   count_value,
    input  logic                          auto_init,
    input  logic                          enable,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          tc_irq,
    output logic                          bus_req,
    input  logic                          bus_gnt,
    input  logic                          drq,
    output logic                          dack_n,
    output logic                          iow_n,
    output logic                          aen,
    output logic                          tc,
    output logic [7:0]                    d_out,
    output logic                          d_oe
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, REQ, SETUP, STROBE, HOLD, DONE} state_t;

    state_t state, state_d;

    // DRQ synchroniser
    logic drq_m, drq_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            drq_m <= 1'b0;
            drq_s <= 1'b0;
        end else begin
            drq_m <= drq;
            drq_s <= drq_m;
        end
    end

    // Sample FIFO, first-word-fall-through
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_d;
    logic [7:0]    head;
    logic          push, pop;

    assign push       = wr_valid && wr_ready;
    assign pop        = (state == DONE);
    assign head       = mem[rd_ptr];
    assign fifo_level = level;

    always_comb begin
        level_d = level;
        if (push && !pop)
            level_d = level + LW'(1);
        else if (pop && !push)
            level_d = level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level    <= level_d;
            wr_ready <= (level_d != LW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Phase timer for SETUP/STROBE/HOLD; restarts on every state change
    logic [15:0] ph_cnt;
    logic        ph_last;

    always_comb begin
        ph_last = 1'b0;
        case (state)
            SETUP:   ph_last = (ph_cnt == 16'(SETUP_CYCLES - 1));
            STROBE:  ph_last = (ph_cnt == 16'(IOW_CYCLES - 1));
            HOLD:    ph_last = (ph_cnt == 16'(HOLD_CYCLES - 1));
            default: ph_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state_d != state)
            ph_cnt <= '0;
        else
            ph_cnt <= ph_cnt + 16'd1;
    end

    // Transfer counter; a load outside IDLE is parked until DONE
    logic [15:0] base, cur, pend_val;
    logic [15:0] base_d, cur_d, pend_val_d, load_val;
    logic        armed, pend, armed_d, pend_d;

    assign load_val = count_load ? count_value : pend_val;

    always_comb begin
        base_d     = base;
        cur_d      = cur;
        armed_d    = armed;
        pend_d     = pend;
        pend_val_d = pend_val;
        case (state)
            IDLE: begin
                if (count_load) begin
                    base_d  = count_value;
                    cur_d   = count_value;
                    armed_d = 1'b1;
                end
            end
            DONE: begin
                pend_d = 1'b0;
                if (pend || count_load) begin
                    base_d  = load_val;
                    cur_d   = load_val;
                    armed_d = 1'b1;
                end else if (cur != 16'd0) begin
                    cur_d = cur - 16'd1;
                end else if (auto_init) begin
                    cur_d = base;
                end else begin
                    armed_d = 1'b0;
                end
            end
            default: begin
                if (count_load) begin
                    pend_d     = 1'b1;
                    pend_val_d = count_value;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base     <= '0;
            cur      <= '0;
            pend_val <= '0;
            armed    <= 1'b0;
            pend     <= 1'b0;
        end else begin
            base     <= base_d;
            cur      <= cur_d;
            pend_val <= pend_val_d;
            armed    <= armed_d;
            pend     <= pend_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (enable && armed && drq_s && level != '0) state_d = REQ;
            REQ:     if (bus_gnt) state_d = SETUP;
            SETUP:   if (ph_last) state_d = STROBE;
            STROBE:  if (ph_last) state_d = HOLD;
            HOLD:    if (ph_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs, decoded from the upcoming state so the flops line up with it
    logic       bus_nx;
    logic       busy_nx, bus_req_nx, dack_n_nx, iow_n_nx, aen_nx, tc_nx, d_oe_nx, tc_irq_nx;
    logic [7:0] d_out_nx;

    always_comb begin
        bus_nx     = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        busy_nx    = (state_d != IDLE);
        bus_req_nx = bus_nx || (state_d == REQ);
        dack_n_nx  = !bus_nx;
        iow_n_nx   = (state_d != STROBE);
        aen_nx     = bus_nx;
        d_oe_nx    = bus_nx;
        tc_nx      = bus_nx && (cur_d == 16'd0);
        d_out_nx   = bus_nx ? head : 8'h00;
        // A load that lands before DONE suppresses the terminal-count interrupt
        tc_irq_nx  = (state_d == DONE) && (cur == 16'd0) && !(pend || count_load);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            bus_req <= 1'b0;
            dack_n  <= 1'b1;
            iow_n   <= 1'b1;
            aen     <= 1'b0;
            d_oe    <= 1'b0;
            tc      <= 1'b0;
            d_out   <= 8'h00;
            tc_irq  <= 1'b0;
        end else begin
            busy    <= busy_nx;
            bus_req <= bus_req_nx;
            dack_n  <= dack_n_nx;
            iow_n   <= iow_n_nx;
            aen     <= aen_nx;
            d_oe    <= d_oe_nx;
            tc      <= tc_nx;
            d_out   <= d_out_nx;
            tc_irq  <= tc_irq_nx;
        end
    end

endmodule
